shared_cnt_sched: RTL and testbench

Round-robin scheduler that shares one CNT_W-bit up-counter between NUM_REQ requesters. Each requester asks for an interval of a given length; the scheduler grants the counter to one requester at a time, runs the count from 0 to the requested length, then pulses that requester's done. It sits between the timing clients of a subsystem and the single shared counter datapath, so the clients do not each need their own counter.

---
 rtl/shared_cnt_sched.sv | 124 ++++++++++++
 tb/tb_shared_cnt_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_cnt_sched.sv
// shared_cnt_sched: round-robin owner of a single shared up-counter.
// Each requester gets the counter for one interval of its latched length,
// then receives a one-cycle done pulse. Outputs are all registered.
// Optional: define SHARED_CNT_SCHED_ABORT_EN to let the owner cancel a run
// by dropping req while RUN is active (no done pulse in that case).
module shared_cnt_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] len,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic [CNT_W-1:0]         cnt,
   output logic                     busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt, owner_inc;
   logic [CNT_W-1:0]   len_q, len_nxt, cnt_nxt;
   logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
   logic               busy_nxt;
   logic               found;
   logic [IDX_W-1:0]   pick, cand;

   // The pointer moves past the finishing owner so it gets lowest priority next.
   assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

   // Round-robin search: first pending request at or above the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and next-output logic; outputs are staged here and registered below.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      len_nxt   = len_q;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      done_nxt  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = RUN;
               owner_nxt = pick;
               len_nxt   = len[int'(pick)*CNT_W +: CNT_W];
               gnt_nxt   = NUM_REQ'(1) << pick;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
`ifdef SHARED_CNT_SCHED_ABORT_EN
            if (!req[owner]) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               cnt_nxt   = '0;
               ptr_nxt   = owner_inc;
            end else
`endif
            if (cnt == len_q) begin
               // Compare before incrementing, so cnt tops out at len and never wraps.
               state_nxt = DONE;
               gnt_nxt   = '0;
               cnt_nxt   = '0;
               done_nxt  = NUM_REQ'(1) << owner;
               ptr_nxt   = owner_inc;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers; async reset clears everything with no done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         len_q <= '0;
         cnt   <= '0;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         len_q <= len_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         done  <= done_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_shared_cnt_sched.sv
// Bench for shared_cnt_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an interval-based model.
module tb_shared_cnt_sched;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*CNT_W-1:0] len;
   logic [CNT_W-1:0]         lens [NUM_REQ];
   logic [NUM_REQ-1:0]       gnt, done;
   logic [CNT_W-1:0]         cnt;
   logic                     busy;

   int n_cmp = 0;
   int n_err = 0;

   // Model: an active interval is (owner, L, phase); phase 0..L is counting,
   // phase L+1 is the done cycle, after which the scheduler is idle one cycle.
   bit m_active;
   int m_owner, m_L, m_phase, m_ptr;

   shared_cnt_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .len(len),
      .gnt(gnt), .done(done), .cnt(cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      len = '0;
      for (int i = 0; i < NUM_REQ; i++) len[i*CNT_W +: CNT_W] = lens[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_ptr    = 0;
      m_phase  = 0;
      m_owner  = 0;
      m_L      = 0;
   endtask

   // Advance the model across one rising edge using the inputs seen at that edge.
   task automatic model_step();
      if (!m_active) begin
         bit f = 0;
         for (int off = 0; off < NUM_REQ; off++) begin
            int i = (m_ptr + off) % NUM_REQ;
            if (!f && req[i]) begin
               f        = 1;
               m_owner  = i;
               m_L      = int'(lens[i]);
               m_phase  = 0;
               m_active = 1;
            end
         end
      end else if (m_phase <= m_L) begin
`ifdef SHARED_CNT_SCHED_ABORT_EN
         if (!req[m_owner]) begin
            m_active = 0;
            m_ptr    = (m_owner + 1) % NUM_REQ;
         end else
`endif
         m_phase++;
      end else begin
         m_active = 0;
         m_ptr    = (m_owner + 1) % NUM_REQ;
      end
   endtask

   task automatic check_model();
      logic [31:0] eg, ed, ec, eb;
      eg = 0; ed = 0; ec = 0; eb = 0;
      if (m_active) begin
         eb = 1;
         if (m_phase <= m_L) begin
            eg = 32'(1) << m_owner;
            ec = 32'(m_phase);
         end else begin
            ed = 32'(1) << m_owner;
         end
      end
      chk("model_gnt",  32'(gnt),  eg);
      chk("model_done", 32'(done), ed);
      chk("model_cnt",  32'(cnt),  ec);
      chk("model_busy", 32'(busy), eb);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int g_own [8];
   int g_cyc [8];
   int ng;
   logic [NUM_REQ-1:0] prev;

   initial begin
      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < NUM_REQ; i++) lens[i] = '0;
      model_reset();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      do_reset();

      // Single requester, len 3
      req = 4'b0001; lens[0] = 8'd3;
      cycle();
      chk("t1_gnt_e0", 32'(gnt), 32'h1);
      chk("t1_cnt_e0", 32'(cnt), 0);
      chk("t1_busy_e0", 32'(busy), 1);
      repeat (3) cycle();
      chk("t1_cnt3", 32'(cnt), 3);
      cycle();
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_gnt_off", 32'(gnt), 0);
      req = '0;
      cycle();
      chk("t1_done_clr", 32'(done), 0);
      chk("t1_idle_busy", 32'(busy), 0);

      // Contention, all lengths 1
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) lens[i] = 8'd1;
      prev = '0; ng = 0;
      for (int c = 1; c <= 18; c++) begin
         cycle();
         if (gnt != 0 && prev == 0 && ng < 8) begin
            for (int b = 0; b < NUM_REQ; b++) if (gnt[b]) g_own[ng] = b;
            g_cyc[ng] = c;
            ng++;
         end
         prev = gnt;
      end
      chk("t2_ngrants", 32'(ng), 5);
      for (int k = 0; k < 5; k++) begin
         chk("t2_order", 32'(g_own[k]), 32'(k % 4));
         chk("t2_spacing", 32'(g_cyc[k]), 32'(1 + 4 * k));
      end
      req = '0;
      repeat (4) cycle();

      // Zero length
      do_reset();
      req = 4'b0100; lens[2] = 8'd0;
      cycle();
      chk("t3_gnt", 32'(gnt), 32'h4);
      chk("t3_cnt", 32'(cnt), 0);
      cycle();
      chk("t3_done", 32'(done), 32'h4);
      chk("t3_gnt_off", 32'(gnt), 0);
      req = '0;
      cycle();

      // Maximum length, len changed mid-run
      do_reset();
      req = 4'b0010; lens[1] = 8'd255;
      cycle();
      repeat (100) cycle();
      lens[1] = 8'd5;
      repeat (155) cycle();
      chk("t4_cnt255", 32'(cnt), 255);
      chk("t4_gnt", 32'(gnt), 32'h2);
      cycle();
      chk("t4_done", 32'(done), 32'h2);
      chk("t4_cnt0", 32'(cnt), 0);
      req = '0;
      cycle();

      // Reset mid-run; pointer must return to 0
      do_reset();
      req = 4'b0001; lens[0] = 8'd1;
      repeat (4) cycle();
      req = 4'b0010; lens[1] = 8'd20;
      cycle();
      repeat (5) cycle();
      chk("t5_cnt5", 32'(cnt), 5);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_async_gnt", 32'(gnt), 0);
      chk("t5_async_cnt", 32'(cnt), 0);
      chk("t5_async_busy", 32'(busy), 0);
      chk("t5_async_done", 32'(done), 0);
      @(negedge clk);
      check_model();
      rst_n = 1'b1;
      req = 4'b0011;
      cycle();
      chk("t5_first_gnt", 32'(gnt), 32'h1);
      req = '0;
      repeat (4) cycle();

      // Owner drops req at cnt=2
      do_reset();
      req = 4'b1000; lens[3] = 8'd6;
      repeat (3) cycle();
      chk("t6_cnt2", 32'(cnt), 2);
      req = '0;
      cycle();
`ifdef SHARED_CNT_SCHED_ABORT_EN
      chk("t6_abort_gnt", 32'(gnt), 0);
      chk("t6_abort_cnt", 32'(cnt), 0);
      chk("t6_abort_done", 32'(done), 0);
      repeat (8) cycle();
`else
      chk("t6_cnt3", 32'(cnt), 3);
      repeat (3) cycle();
      chk("t6_cnt6", 32'(cnt), 6);
      cycle();
      chk("t6_done", 32'(done), 32'h8);
      cycle();
`endif

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m_active && m_phase <= m_L && i == m_owner) begin
`ifdef SHARED_CNT_SCHED_ABORT_EN
               req[i] = ($urandom_range(0, 29) != 0);
`else
               req[i] = 1'b1;
`endif
            end else if ($urandom_range(0, 3) == 0) begin
               req[i] = ~req[i];
            end
            lens[i] = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 255))
                                                   : CNT_W'($urandom_range(0, 6));
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
